mem_stream_loader: RTL and testbench

//  Byte-stream program loader for pipeline_top memories: the write-side counterpart of the bench's memory dump/readback.

---
 rtl/mem_stream_loader.sv | 150 +++++++++++++++
 tb/tb_mem_stream_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_loader.sv
// Byte-stream program loader: framed commands on a valid/ready byte port become IMEM word / DMEM doubleword writes.
// Optional trailer checksum per frame when LOADER_CHECKSUM_EN is defined.
module mem_stream_loader #(
  parameter int IADDR_W = 10,
  parameter int DADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [63:0]        dmem_wdata,
  output logic               core_hold,
  output logic               busy,
  output logic               err
);

  typedef enum logic [3:0] {
    IDLE, LEN0, LEN1, ADR0, ADR1, PAYLD, WRITE, RUN, CSUM
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CSUM;
  logic [7:0] csum;
  logic       csum_bad;
`else
  localparam state_t END_STATE = IDLE;
`endif

  state_t      state;
  logic        is_dmem;
  logic [7:0]  len_lo;
  logic [7:0]  addr_lo;
  logic [15:0] remaining;
  logic [63:0] asm_q;
  logic [2:0]  bcnt;

  logic [15:0] addr_full;
  logic [63:0] asm_next;
  logic [2:0]  last_idx;

  assign addr_full = {in_data, addr_lo};
  assign asm_next  = {in_data, asm_q[63:8]};
  assign last_idx  = is_dmem ? 3'd7 : 3'd3;

  // Handshake and busy are pure decodes of the state register.
  assign in_ready = (state != WRITE);
  assign busy     = (state != IDLE) && (state != RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      is_dmem    <= 1'b0;
      len_lo     <= '0;
      addr_lo    <= '0;
      remaining  <= '0;
      asm_q      <= '0;
      bcnt       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      core_hold  <= 1'b1;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
      csum_bad   <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low every cycle with non-blocking assignment; only the PAYLD->WRITE edge raises them.
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      case (state)
        IDLE, RUN: begin
          state <= IDLE;
          if (in_valid) begin
            case (in_data)
              8'h01: begin is_dmem <= 1'b0; core_hold <= 1'b1; state <= LEN0; end
              8'h02: begin is_dmem <= 1'b1; core_hold <= 1'b1; state <= LEN0; end
              8'h03: begin
                state <= RUN;
`ifdef LOADER_CHECKSUM_EN
                core_hold <= csum_bad;
`else
                core_hold <= 1'b0;
`endif
              end
              8'h04:   core_hold <= 1'b1;
              default: err <= 1'b1;
            endcase
          end
        end
        LEN0: if (in_valid) begin len_lo <= in_data; state <= LEN1; end
        LEN1: if (in_valid) begin remaining <= {in_data, len_lo}; state <= ADR0; end
        ADR0: if (in_valid) begin addr_lo <= in_data; state <= ADR1; end
        ADR1: if (in_valid) begin
          // Start address is aligned to the unit size; the low bits of ADDR are dropped.
          if (is_dmem) dmem_addr <= DADDR_W'(addr_full & 16'hFFF8);
          else         imem_addr <= IADDR_W'(addr_full & 16'hFFFC);
          bcnt  <= '0;
          asm_q <= '0;
`ifdef LOADER_CHECKSUM_EN
          csum  <= '0;
`endif
          state <= (remaining == 16'd0) ? END_STATE : PAYLD;
        end
        PAYLD: if (in_valid) begin
          asm_q <= asm_next;
          bcnt  <= bcnt + 3'd1;
`ifdef LOADER_CHECKSUM_EN
          csum  <= csum + in_data;
`endif
          if (bcnt == last_idx) begin
            bcnt  <= '0;
            state <= WRITE;
            if (is_dmem) begin
              dmem_we    <= 1'b1;
              dmem_wdata <= asm_next;
            end else begin
              imem_we    <= 1'b1;
              imem_wdata <= asm_next[63:32];
            end
          end
        end
        WRITE: begin
          if (is_dmem) dmem_addr <= dmem_addr + DADDR_W'(8);
          else         imem_addr <= imem_addr + IADDR_W'(4);
          remaining <= remaining - 16'd1;
          state     <= (remaining == 16'd1) ? END_STATE : PAYLD;
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: if (in_valid) begin
          csum_bad <= (in_data != csum);
          if (in_data != csum) err <= 1'b1;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Self-checking bench for mem_stream_loader: frames are modelled into an expected-write queue and
// compared against the memory strobes as they appear.
module tb_mem_stream_loader;

  localparam int IADDR_W = 10;
  localparam int DADDR_W = 10;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               imem_we;
  logic [IADDR_W-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [63:0]        dmem_wdata;
  logic               core_hold;
  logic               busy;
  logic               err;

  typedef struct {
    bit          is_d;
    int unsigned addr;
    logic [63:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] pl_q[$];
  int checks = 0;
  int errors = 0;

  mem_stream_loader #(.IADDR_W(IADDR_W), .DADDR_W(DADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .core_hold(core_hold), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && (imem_we || dmem_we)) begin
      checks++;
      if (imem_we && dmem_we) begin
        errors++;
        $display("FAIL both_we: imem_we and dmem_we high together");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: imem_we=%0b addr=%h / dmem_we=%0b addr=%h", imem_we, imem_addr, dmem_we, dmem_addr);
      end else begin
        e = exp_q.pop_front();
        if (e.is_d) begin
          if (!dmem_we || dmem_addr !== e.addr[DADDR_W-1:0] || dmem_wdata !== e.data) begin
            errors++;
            $display("FAIL dmem_write: got we=%0b addr=%h data=%h, want addr=%h data=%h",
                     dmem_we, dmem_addr, dmem_wdata, e.addr[DADDR_W-1:0], e.data);
          end
        end else begin
          if (!imem_we || imem_addr !== e.addr[IADDR_W-1:0] || imem_wdata !== e.data[31:0]) begin
            errors++;
            $display("FAIL imem_write: got we=%0b addr=%h data=%h, want addr=%h data=%h",
                     imem_we, imem_addr, imem_wdata, e.addr[IADDR_W-1:0], e.data[31:0]);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bit done = 0;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    in_valid = 1'b1;
    in_data  = b;
    while (!done && n < 50) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %h not accepted, want accept within 50 cycles", b);
    end
  endtask

  task automatic send_stream(input int max_gap);
    foreach (tx_q[i]) send_byte(tx_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    tx_q.delete();
  endtask

  // Builds a frame from pl_q into tx_q and queues the writes it must produce.
  task automatic build_frame(input logic [7:0] cmd, input int unsigned len, input int unsigned addr);
    int unsigned bpu, w, base;
    logic [7:0] sum;
    wr_t e;
    bpu  = (cmd == 8'h02) ? 8 : 4;
    w    = (cmd == 8'h02) ? DADDR_W : IADDR_W;
    base = addr & ~(bpu - 1);
    sum  = 8'h00;
    tx_q.push_back(cmd);
    tx_q.push_back(8'(len));
    tx_q.push_back(8'(len >> 8));
    tx_q.push_back(8'(addr));
    tx_q.push_back(8'(addr >> 8));
    for (int u = 0; u < int'(len); u++) begin
      e.is_d = (cmd == 8'h02);
      e.addr = (base + u * bpu) % (1 << w);
      e.data = '0;
      for (int k = 0; k < int'(bpu); k++) begin
        e.data[8*k +: 8] = pl_q[u*bpu + k];
        tx_q.push_back(pl_q[u*bpu + k]);
        sum += pl_q[u*bpu + k];
      end
      exp_q.push_back(e);
    end
`ifdef LOADER_CHECKSUM_EN
    tx_q.push_back(sum);
`endif
    pl_q.delete();
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: %0d writes outstanding, want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_idle(input string name, input logic hold, input logic e);
    checks++;
    if ({busy, core_hold, err, in_ready} !== {1'b0, hold, e, 1'b1}) begin
      errors++;
      $display("FAIL %s_status: busy=%0b core_hold=%0b err=%0b in_ready=%0b, want 0 %0b %0b 1",
               name, busy, core_hold, err, in_ready, hold, e);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({in_ready, imem_we, dmem_we, core_hold, busy, err} !== 6'b100100) begin
      errors++;
      $display("FAIL %s_ctrl: ready/iwe/dwe/hold/busy/err=%b, want 100100", name,
               {in_ready, imem_we, dmem_we, core_hold, busy, err});
    end
    checks++;
    if (imem_addr !== '0 || dmem_addr !== '0 || imem_wdata !== '0 || dmem_wdata !== '0) begin
      errors++;
      $display("FAIL %s_data: iaddr=%h daddr=%h iwdata=%h dwdata=%h, want all 0", name,
               imem_addr, dmem_addr, imem_wdata, dmem_wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
  endtask

  task automatic test_imem();
    pl_q = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    build_frame(8'h01, 2, 16'h0000);
    send_stream(0);
    drain("imem");
    check_idle("imem", 1'b1, 1'b0);
  endtask

  task automatic test_dmem();
    pl_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build_frame(8'h02, 1, 16'h0008);
    send_stream(0);
    drain("dmem");
    check_idle("dmem", 1'b1, 1'b0);
  endtask

  task automatic test_run();
    send_byte(8'h03, 0);
    check_idle("run", 1'b0, 1'b0);
    build_frame(8'h01, 0, 16'h0000);
    send_byte(tx_q.pop_front(), 0);
    checks++;
    if (core_hold !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_reload: core_hold=%0b busy=%0b, want 1 1", core_hold, busy);
    end
    send_stream(0);
    drain("run_len0");
    check_idle("run_len0", 1'b1, 1'b0);
  endtask

  task automatic test_halt();
    send_byte(8'h03, 0);
    check_idle("halt_run", 1'b0, 1'b0);
    send_byte(8'h04, 0);
    check_idle("halt", 1'b1, 1'b0);
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 8; i++) pl_q.push_back(8'($urandom));
    build_frame(8'h01, 2, 16'h03FE);
    send_stream(0);
    drain("imem_wrap");
    for (int i = 0; i < 16; i++) pl_q.push_back(8'($urandom));
    build_frame(8'h02, 2, 16'h03FF);
    send_stream(0);
    drain("dmem_wrap");
    build_frame(8'h02, 0, 16'h0010);
    send_stream(0);
    drain("dmem_len0");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 24; i++) pl_q.push_back(8'($urandom));
    build_frame(8'h02, 3, 16'h0123);
    send_stream(3);
    drain("stall_dmem");
    for (int i = 0; i < 12; i++) pl_q.push_back(8'($urandom));
    build_frame(8'h01, 3, 16'h0042);
    send_stream(2);
    drain("stall_imem");
  endtask

  task automatic test_error();
    send_byte(8'h7F, 0);
    check_idle("bad_cmd", 1'b1, 1'b1);
    pl_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    build_frame(8'h01, 1, 16'h0020);
    send_stream(0);
    drain("after_err");
    check_idle("after_err", 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    tx_q = '{8'h02, 8'h01, 8'h00, 8'h18, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_stream(0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("reset_mid");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) pl_q.push_back(8'(8'hA0 + i));
    build_frame(8'h02, 1, 16'h0018);
    send_stream(0);
    drain("after_reset_mid");
  endtask

  initial begin
    test_reset();
    test_imem();
    test_dmem();
    test_run();
    test_halt();
    test_boundary();
    test_stall();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
